uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// ----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and defaults for the UART transmit arbiter.
//   arb_state_t  : arbiter FSM state encoding
//   byte_t       : one transmit byte
//   DEF_N_REQ    : default number of requesters
//   DEF_TIMEOUT  : default START/HOLD abort limit in clk cycles
// ----------------------------------------------------------------------------
package uart_arb_pkg;

   localparam int DEF_N_REQ   = 4;
   localparam int DEF_TIMEOUT = 4096;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_SEND  = 2'd2,
      ST_HOLD  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search begins one past the previous
// owner and wraps, so the previous owner has the lowest priority.
//   i_req        : request vector
//   i_last_owner : index of the requester that owned the bus last
//   o_grant      : index of the winner (meaningful when o_any_req=1)
//   o_any_req    : at least one request is pending
// ----------------------------------------------------------------------------
module rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter  int N_REQ = DEF_N_REQ,
   localparam int IW    = $clog2(N_REQ)
)(
   input  logic [N_REQ-1:0] i_req,
   input  logic [IW-1:0]    i_last_owner,
   output logic [IW-1:0]    o_grant,
   output logic             o_any_req
);

   always_comb begin : search
      logic [IW-1:0] w_idx;
      o_grant   = '0;
      o_any_req = 1'b0;
      w_idx     = '0;
      // k = N_REQ wraps back to the last owner itself, so a lone requester
      // can win again.
      for (int k = 1; k <= N_REQ; k++) begin
         w_idx = IW'((int'(i_last_owner) + k) % N_REQ);
         if (!o_any_req && i_req[w_idx]) begin
            o_grant   = w_idx;
            o_any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between N_REQ byte requesters. The owner of a
// packet keeps the transmitter until it sends a byte marked last. Stuck
// handshakes in START or HOLD are aborted after TIMEOUT cycles.
//   clk, reset   : system clock, asynchronous active-high reset
//   req_valid    : per-requester byte available
//   req_data     : packed bytes, requester i on [8i+7:8i]
//   req_last     : per-requester end-of-packet flag
//   req_ready    : one-cycle accept pulse to the owner
//   grant_id     : current owner (valid while active=1)
//   active       : a requester owns the transmitter
//   tx_data      : byte to the UART
//   tx_start     : start request to the UART
//   tx_busy      : UART busy (asynchronous, synchronized internally)
//   err_timeout  : one-cycle pulse when START or HOLD is aborted
// ----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter  int N_REQ   = DEF_N_REQ,
   parameter  int TIMEOUT = DEF_TIMEOUT,
   localparam int IW      = $clog2(N_REQ),
   localparam int CW      = $clog2(TIMEOUT)
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [IW-1:0]      grant_id,
   output logic               active,
   output logic [7:0]         tx_data,
   output logic               tx_start,
   input  logic               tx_busy,
   output logic               err_timeout
);

   arb_state_t                r_state, w_state_nxt;
   logic                      r_busy_m, r_busy_s;
   logic [IW-1:0]             r_grant, w_grant_nxt;
   logic [IW-1:0]             r_last_owner;
   logic [IW-1:0]             w_rr_grant;
   logic                      w_any_req;
   byte_t                     r_tx_data;
   logic                      r_last;
   logic                      r_tx_start;
   logic [N_REQ-1:0]          r_req_ready, w_req_ready_nxt;
   logic                      r_err, w_err_nxt;
   logic                      r_active;
   logic                      r_seen_low;
   logic [CW-1:0]             r_cnt;
   logic                      w_load, w_release, w_timeout;
   logic [N_REQ-1:0][7:0]     w_bytes;

   assign w_bytes     = req_data;
   assign w_timeout   = (r_cnt == CW'(TIMEOUT - 1));

   assign req_ready   = r_req_ready;
   assign grant_id    = r_grant;
   assign active      = r_active;
   assign tx_data     = r_tx_data;
   assign tx_start    = r_tx_start;
   assign err_timeout = r_err;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .i_req        (req_valid),
      .i_last_owner (r_last_owner),
      .o_grant      (w_rr_grant),
      .o_any_req    (w_any_req)
   );

   // tx_busy comes from another clock domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy_m <= 1'b0;
         r_busy_s <= 1'b0;
      end else begin
         r_busy_m <= tx_busy;
         r_busy_s <= r_busy_m;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_last_owner <= IW'(N_REQ - 1);
         r_active     <= 1'b0;
         r_tx_start   <= 1'b0;
         r_tx_data    <= '0;
         r_last       <= 1'b0;
         r_req_ready  <= '0;
         r_err        <= 1'b0;
         r_cnt        <= '0;
         r_seen_low   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_active    <= (w_state_nxt != ST_IDLE);
         r_tx_start  <= (w_state_nxt == ST_START);
         r_req_ready <= w_req_ready_nxt;
         r_err       <= w_err_nxt;
         // Byte and last flag are captured once; later input changes are ignored.
         if (w_load) begin
            r_tx_data <= w_bytes[w_grant_nxt];
            r_last    <= req_last[w_grant_nxt];
         end
         if (w_release)
            r_last_owner <= r_grant;
         if (w_state_nxt != r_state)
            r_cnt <= '0;
         else if (r_state == ST_START || r_state == ST_HOLD)
            r_cnt <= r_cnt + CW'(1);
         // Acceptance needs a low-to-high busy transition seen inside START,
         // so a busy left over from an earlier byte is not mistaken for it.
         if (w_state_nxt == ST_START && r_state != ST_START)
            r_seen_low <= 1'b0;
         else if (r_state == ST_START && !r_busy_s)
            r_seen_low <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_grant_nxt     = r_grant;
      w_req_ready_nxt = '0;
      w_err_nxt       = 1'b0;
      w_load          = 1'b0;
      w_release       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_grant_nxt = w_rr_grant;
               w_load      = 1'b1;
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            // An accepted byte wins over a coincident timeout.
            if (r_busy_s && r_seen_low) begin
               w_req_ready_nxt[r_grant] = 1'b1;
               w_state_nxt              = ST_SEND;
            end else if (w_timeout) begin
               w_err_nxt   = 1'b1;
               w_release   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (!r_busy_s) begin
               if (r_last) begin
                  w_release   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            // Packet lock: only the owner may continue.
            if (req_valid[r_grant]) begin
               w_load      = 1'b1;
               w_state_nxt = ST_START;
            end else if (w_timeout) begin
               w_err_nxt   = 1'b1;
               w_release   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

   localparam int N        = 4;
   localparam int T        = 32;
   localparam int BUSY_LEN = 6;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid, req_last, req_ready;
   logic [8*N-1:0] req_data;
   logic [1:0]     grant_id;
   logic           active, tx_start, tx_busy, err_timeout;
   logic [7:0]     tx_data;

   int n_cmp = 0;
   int n_fail = 0;

   // Per-requester stimulus: {last, data}; tail written by tests, head by driver.
   logic [8:0] stim [N][16];
   int         head [N];
   int         tail [N];

   // Accept log filled by the monitor.
   int         acc_n = 0;
   int         acc_id [64];
   logic [7:0] acc_data [64];
   int         multi_n = 0;

   bit uart_en = 1'b1;
   bit busy_force = 1'b0;
   int bcnt;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .grant_id(grant_id),
      .active(active), .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy), .err_timeout(err_timeout)
   );

   // Requester driver: presents the head byte, advances on req_ready.
   initial begin
      req_valid = '0; req_data = '0; req_last = '0;
      for (int i = 0; i < N; i++) head[i] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (req_ready[i] && head[i] < tail[i]) head[i]++;
            if (head[i] < tail[i]) begin
               req_valid[i]      = 1'b1;
               req_data[8*i +: 8] = stim[i][head[i]][7:0];
               req_last[i]       = stim[i][head[i]][8];
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   // UART model: busy for BUSY_LEN cycles after seeing tx_start.
   initial begin
      tx_busy = 1'b0; bcnt = 0;
      forever begin
         @(negedge clk);
         if (busy_force) begin tx_busy = 1'b1; bcnt = 0; end
         else if (!uart_en) begin tx_busy = 1'b0; bcnt = 0; end
         else if (bcnt > 0) begin bcnt--; tx_busy = (bcnt != 0); end
         else if (tx_start) begin bcnt = BUSY_LEN; tx_busy = 1'b1; end
      end
   end

   // Monitor: logs every accepted byte.
   initial begin
      forever begin
         @(negedge clk);
         if (req_ready !== '0 && acc_n < 64) begin
            if ($countones(req_ready) != 1) multi_n++;
            for (int i = 0; i < N; i++) if (req_ready[i]) acc_id[acc_n] = i;
            acc_data[acc_n] = tx_data;
            acc_n++;
         end
      end
   end

   task automatic enq(input int i, input logic last, input logic [7:0] d);
      stim[i][tail[i]] = {last, d};
      tail[i]++;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      @(posedge clk); #1;
      n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b need 0", tx_start); end
      n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h need 00", tx_data); end
      n_cmp++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b need 0000", req_ready); end
      n_cmp++; if ({active, grant_id, err_timeout} !== 4'b0) begin n_fail++; $display("FAIL rst_ctrl: got %b need 0000", {active, grant_id, err_timeout}); end
      #1 reset = 1'b0;
      repeat (2) @(posedge clk); #1;
      n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL rst_idle: active=%b need 0", active); end
   endtask

   task automatic test_single;
      int t; int base;
      do_reset; base = acc_n;
      enq(0, 1'b1, 8'h55);
      t = 0; while (tx_start !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
      n_cmp++; if ({tx_start, active, grant_id, tx_data} !== {1'b1, 1'b1, 2'd0, 8'h55}) begin n_fail++; $display("FAIL single_start: got %b/%b/%0d/%h need 1/1/0/55", tx_start, active, grant_id, tx_data); end
      t = 0; while (req_ready === 4'b0 && t < 50) begin @(posedge clk); #1; t++; end
      n_cmp++; if ({req_ready, tx_start, tx_busy} !== {4'b0001, 1'b0, 1'b1}) begin n_fail++; $display("FAIL single_accept: ready=%b start=%b busy=%b need 0001/0/1", req_ready, tx_start, tx_busy); end
      @(posedge clk); #1;
      n_cmp++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL single_pulse: ready=%b need 0000", req_ready); end
      t = 0; while (active === 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
      n_cmp++; if ({active, tx_busy} !== 2'b00) begin n_fail++; $display("FAIL single_release: active=%b busy=%b need 0/0", active, tx_busy); end
      n_cmp++; if (acc_n - base != 1 || acc_id[base] != 0 || acc_data[base] !== 8'h55) begin n_fail++; $display("FAIL single_log: n=%0d id=%0d data=%h need 1/0/55", acc_n - base, acc_id[base], acc_data[base]); end
   endtask

   task automatic test_contention;
      int t; int base;
      int exp_id [5] = '{0, 1, 2, 3, 0};
      logic [7:0] exp_d [5] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
      do_reset; base = acc_n;
      enq(0, 1'b1, 8'hC0); enq(0, 1'b1, 8'hC4);
      enq(1, 1'b1, 8'hC1); enq(2, 1'b1, 8'hC2); enq(3, 1'b1, 8'hC3);
      t = 0; while (!(acc_n - base == 5 && active === 1'b0) && t < 500) begin @(posedge clk); #1; t++; end
      n_cmp++; if (acc_n - base != 5) begin n_fail++; $display("FAIL cont_count: got %0d need 5", acc_n - base); end
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (acc_id[base+k] != exp_id[k] || acc_data[base+k] !== exp_d[k]) begin
            n_fail++; $display("FAIL cont_order[%0d]: got %0d/%h need %0d/%h", k, acc_id[base+k], acc_data[base+k], exp_id[k], exp_d[k]);
         end
      end
      n_cmp++; if (multi_n != 0) begin n_fail++; $display("FAIL cont_onehot: multi=%0d need 0", multi_n); end
   endtask

   task automatic test_packet_lock;
      int t; int base;
      int exp_id [5] = '{2, 2, 2, 3, 1};
      logic [7:0] exp_d [5] = '{8'hA1, 8'hA2, 8'hA3, 8'h33, 8'h11};
      do_reset; base = acc_n;
      enq(2, 1'b0, 8'hA1); enq(2, 1'b0, 8'hA2); enq(2, 1'b1, 8'hA3);
      t = 0; while (!(active === 1'b1 && grant_id === 2'd2) && t < 50) begin @(posedge clk); #1; t++; end
      enq(1, 1'b1, 8'h11); enq(3, 1'b1, 8'h33);
      t = 0; while (!(acc_n - base == 5 && active === 1'b0) && t < 500) begin @(posedge clk); #1; t++; end
      n_cmp++; if (acc_n - base != 5) begin n_fail++; $display("FAIL lock_count: got %0d need 5", acc_n - base); end
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (acc_id[base+k] != exp_id[k] || acc_data[base+k] !== exp_d[k]) begin
            n_fail++; $display("FAIL lock_order[%0d]: got %0d/%h need %0d/%h", k, acc_id[base+k], acc_data[base+k], exp_id[k], exp_d[k]);
         end
      end
   endtask

   task automatic test_start_timeout;
      int t; int base; int cnt;
      do_reset; base = acc_n;
      uart_en = 1'b0;
      enq(2, 1'b1, 8'h5A);
      t = 0; while (tx_start !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
      cnt = 1; t = 0;
      while (err_timeout !== 1'b1 && t < T + 20) begin
         @(posedge clk); #1; t++;
         if (err_timeout !== 1'b1 && tx_start === 1'b1) cnt++;
      end
      n_cmp++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL start_to_pulse: err=%b need 1", err_timeout); end
      n_cmp++; if (cnt != T) begin n_fail++; $display("FAIL start_to_cycles: got %0d need %0d", cnt, T); end
      n_cmp++; if ({tx_start, active, req_ready} !== 6'b0) begin n_fail++; $display("FAIL start_to_abort: start=%b active=%b ready=%b need 0/0/0000", tx_start, active, req_ready); end
      n_cmp++; if (acc_n != base) begin n_fail++; $display("FAIL start_to_noready: accepted=%0d need 0", acc_n - base); end
      @(posedge clk); #1;
      n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL start_to_width: err=%b need 0", err_timeout); end
      uart_en = 1'b1;
      t = 0; while (!(acc_n - base == 1 && active === 1'b0) && t < 300) begin @(posedge clk); #1; t++; end
      n_cmp++; if (acc_n - base != 1 || acc_id[base] != 2 || acc_data[base] !== 8'h5A) begin n_fail++; $display("FAIL start_to_retry: n=%0d id=%0d data=%h need 1/2/5a", acc_n - base, acc_id[base], acc_data[base]); end
   endtask

   task automatic test_hold_timeout;
      int t; int base; int cnt;
      do_reset; base = acc_n;
      enq(1, 1'b0, 8'h10);
      t = 0; while (req_ready === 4'b0 && t < 50) begin @(posedge clk); #1; t++; end
      n_cmp++; if ({req_ready, tx_data} !== {4'b0010, 8'h10}) begin n_fail++; $display("FAIL hold_accept: ready=%b data=%h need 0010/10", req_ready, tx_data); end
      enq(2, 1'b1, 8'h22);
      cnt = 0;
      repeat (10) begin @(posedge clk); #1; cnt++; end
      n_cmp++; if ({active, grant_id, tx_start} !== {1'b1, 2'd1, 1'b0}) begin n_fail++; $display("FAIL hold_lock: active=%b id=%0d start=%b need 1/1/0", active, grant_id, tx_start); end
      t = 0; while (err_timeout !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; cnt++; end
      n_cmp++; if (err_timeout !== 1'b1 || cnt != T + 6) begin n_fail++; $display("FAIL hold_to_pulse: err=%b cycles=%0d need 1/%0d", err_timeout, cnt, T + 6); end
      n_cmp++; if (active !== 1'b0 || acc_n - base != 1) begin n_fail++; $display("FAIL hold_to_release: active=%b n=%0d need 0/1", active, acc_n - base); end
      @(posedge clk); #1;
      n_cmp++; if ({active, grant_id} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL hold_to_next: active=%b id=%0d need 1/2", active, grant_id); end
      t = 0; while (!(acc_n - base == 2 && active === 1'b0) && t < 100) begin @(posedge clk); #1; t++; end
      n_cmp++; if (acc_n - base != 2 || acc_id[base+1] != 2 || acc_data[base+1] !== 8'h22) begin n_fail++; $display("FAIL hold_to_after: n=%0d id=%0d data=%h need 2/2/22", acc_n - base, acc_id[base+1], acc_data[base+1]); end
   endtask

   task automatic test_busy_preset;
      int t; int base;
      do_reset;
      busy_force = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      base = acc_n;
      enq(3, 1'b1, 8'h3C);
      t = 0; while (tx_start !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
      repeat (10) begin @(posedge clk); #1; end
      n_cmp++; if (tx_start !== 1'b1 || acc_n != base) begin n_fail++; $display("FAIL preset_no_accept: start=%b accepted=%0d need 1/0", tx_start, acc_n - base); end
      busy_force = 1'b0; uart_en = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      uart_en = 1'b1;
      t = 0; while (!(acc_n - base == 1 && active === 1'b0) && t < 100) begin @(posedge clk); #1; t++; end
      n_cmp++; if (acc_n - base != 1 || acc_id[base] != 3 || acc_data[base] !== 8'h3C) begin n_fail++; $display("FAIL preset_accept: n=%0d id=%0d data=%h need 1/3/3c", acc_n - base, acc_id[base], acc_data[base]); end
   endtask

   task automatic test_reset_mid;
      int t; int base;
      int exp_id [4] = '{0, 0, 1, 1};
      logic [7:0] exp_d [4] = '{8'hB0, 8'hD0, 8'hB1, 8'hD1};
      do_reset; base = acc_n;
      enq(0, 1'b1, 8'hB0);
      t = 0; while (!(acc_n - base == 1 && active === 1'b0) && t < 100) begin @(posedge clk); #1; t++; end
      enq(1, 1'b1, 8'hB1);
      t = 0; while (req_ready === 4'b0 && t < 50) begin @(posedge clk); #1; t++; end
      n_cmp++; if ({req_ready, tx_busy} !== {4'b0010, 1'b1}) begin n_fail++; $display("FAIL mid_send: ready=%b busy=%b need 0010/1", req_ready, tx_busy); end
      #2 reset = 1'b1;
      #1;
      n_cmp++; if ({tx_start, tx_data, req_ready, grant_id, active, err_timeout} !== 17'b0) begin n_fail++; $display("FAIL mid_reset_clear: start=%b data=%h ready=%b id=%0d active=%b err=%b need all 0", tx_start, tx_data, req_ready, grant_id, active, err_timeout); end
      enq(0, 1'b1, 8'hD0); enq(1, 1'b1, 8'hD1);
      @(posedge clk); @(posedge clk); #1 reset = 1'b0;
      t = 0; while (!(acc_n - base == 4 && active === 1'b0) && t < 300) begin @(posedge clk); #1; t++; end
      n_cmp++; if (acc_n - base != 4) begin n_fail++; $display("FAIL mid_count: got %0d need 4", acc_n - base); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (acc_id[base+k] != exp_id[k] || acc_data[base+k] !== exp_d[k]) begin
            n_fail++; $display("FAIL mid_order[%0d]: got %0d/%h need %0d/%h", k, acc_id[base+k], acc_data[base+k], exp_id[k], exp_d[k]);
         end
      end
      n_cmp++; if (multi_n != 0) begin n_fail++; $display("FAIL final_onehot: multi=%0d need 0", multi_n); end
   endtask

   initial begin
      reset = 1'b1;
      for (int i = 0; i < N; i++) tail[i] = 0;
      test_reset;
      test_single;
      test_contention;
      test_packet_lock;
      test_start_timeout;
      test_hold_timeout;
      test_busy_preset;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
